qk_score_scheduler: RTL and testbench
=====================================

Name: qk_score_scheduler

Overview:
- Sequences the QK dot-product unit over one Q tile × K tile.
- Generates row-major (q_idx, k_idx) operand addresses for the Q/K tile buffers, drives the dot-product valid/ready handshake, and tags each returned score with its row/col.
- Sits between the tile buffers and the dot-product unit upstream, and the softmax/online-max stage downstream.

Parameters:
- BR, 8: max Q rows per tile.
- BC, 8: max K rows per tile.
- TAG_DEPTH, 4: in-flight tag FIFO depth (power of two, ≥2).
- ROW_W, $clog2(BR): row index width (min 1).
- COL_W, $clog2(BC): column index width (min 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  launch tile; sampled only in IDLE.
- n_q  in  ROW_W+1  valid Q rows this tile, 0..BR; latched at start.
- n_k  in  COL_W+1  valid K rows this tile, 0..BC; latched at start.
- busy  out  1  high in ISSUE/DRAIN.
- done  out  1  one-cycle pulse at tile completion.
- q_idx  out  ROW_W  Q buffer read address for current issue.
- k_idx  out  COL_W  K buffer read address for current issue.
- dp_vld_out  out  1  to dot-product vld_in.
- dp_rdy_in  in  1  from dot-product rdy_out.
- dp_rdy_out  out  1  to dot-product rdy_in; equals score_rdy_in.
- dp_vld_in  in  1  from dot-product vld_out.
- s_in  in  INT_WIDTH  score from dot-product s_out (INT_T).
- score_vld_out  out  1  tagged score valid downstream.
- score_rdy_in  in  1  downstream ready.
- s_out  out  INT_WIDTH  score, passthrough of s_in.
- s_row  out  ROW_W  row tag of s_out.
- s_col  out  COL_W  column tag of s_out.
- s_last  out  1  s_out is the last score of the tile.
- err  out  1  sticky: result arrived with empty tag FIFO.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and tag FIFO cleared; err cleared.
- Reset mid-tile aborts the tile, drops all tags, and emits no done.
- States:
  - IDLE: on start, latch n_q/n_k and zero q_idx/k_idx. If n_q==0 or n_k==0, go to DONE; else go to ISSUE.
  - ISSUE: dp_vld_out = !tag_full. Issue fires on dp_vld_out && dp_rdy_in. On fire:
    - Push tag {q_idx, k_idx, last}.
    - If k_idx==n_k-1, k_idx wraps to 0 and q_idx increments; else k_idx increments.
    - On firing pair (n_q-1, n_k-1), go to DRAIN and drop dp_vld_out the next cycle.
  - DRAIN: no issue. When tag FIFO is empty and score_vld_out is low, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy is 0 in DONE.
- start outside IDLE is ignored. n_q/n_k changes after start have no effect.
- q_idx/k_idx are valid combinationally while dp_vld_out=1. Buffers read asynchronously, so operands are presented the same cycle.
- dp_rdy_out = score_rdy_in, combinational, matching the dot-product's ready passthrough.
- Result path:
  - score_vld_out = dp_vld_in && !tag_empty.
  - s_out = s_in; s_row, s_col, and s_last come from the FIFO head.
  - Pop fires on score_vld_out && score_rdy_in.
  - If dp_vld_in && tag_empty, set err and drop the result.
- Push and pop in the same cycle are legal; occupancy is unchanged. Full/empty are computed on registered occupancy; no bypass.
- Ordering: scores emerge strictly in issue order (dot-product is in-order, 1-cycle latency). Total scores per tile = n_q*n_k.
- s_last=1 only on the tag for pair (n_q-1, n_k-1).
- Throughput: 1 issue/cycle when dp_rdy_in and score_rdy_in are steady high.
- Tile latency from start to done = n_q*n_k + 3 cycles: IDLE→ISSUE 1, issues, DP latency 1, DRAIN→DONE 1.
- Downstream stall (score_rdy_in=0) freezes the dot-product. The tag FIFO holds at most TAG_DEPTH outstanding tags, and issue stops when full.

Test Plan:
1. start, n_q=2, n_k=3, all ready high -> 6 scores with tags (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); s_last only on (1,2); done pulses 9 cycles after start; err=0.
2. n_q=8, n_k=8, score_rdy_in toggled 1/0 each cycle -> 64 scores in row-major order; tag occupancy never exceeds TAG_DEPTH; no drops or duplicates.
3. score_rdy_in held 0 for 10 cycles mid-tile -> dp_vld_out drops once FIFO full (4); s_out/tags stable; resumes with correct next index.
4. start with n_k=0 -> no dp_vld_out; done pulses 1 cycle later; busy stays 0.
5. rst asserted at the 5th issue of a 4×4 tile -> all outputs 0 next cycle; no done; a new start then runs a full tile correctly.
6. dp_vld_in forced high while idle -> err sets and stays 1 until rst; score_vld_out stays 0.

Source files
------------

// File: rtl/qk_score_scheduler_if.sv
// qk_score_scheduler_if
// Groups the two streaming sides of the QK score scheduler into one bundle.
//   Dot-product side : q_idx/k_idx operand addresses, dp_vld_out/dp_rdy_in issue
//                      handshake, dp_vld_in/dp_rdy_out/s_in result handshake.
//   Downstream side  : score_vld_out/score_rdy_in handshake, s_out score and its
//                      s_row/s_col/s_last tag.
// The master modport is the scheduler. The slave modport is its surroundings:
// the dot-product unit and the softmax stage.
interface qk_score_scheduler_if #(
    parameter int ROW_W     = 3,
    parameter int COL_W     = 3,
    parameter int INT_WIDTH = 16
);
    logic [ROW_W-1:0]     q_idx;
    logic [COL_W-1:0]     k_idx;
    logic                 dp_vld_out;
    logic                 dp_rdy_in;
    logic                 dp_rdy_out;
    logic                 dp_vld_in;
    logic [INT_WIDTH-1:0] s_in;
    logic                 score_vld_out;
    logic                 score_rdy_in;
    logic [INT_WIDTH-1:0] s_out;
    logic [ROW_W-1:0]     s_row;
    logic [COL_W-1:0]     s_col;
    logic                 s_last;

    modport master (
        output q_idx, k_idx, dp_vld_out, dp_rdy_out,
        output score_vld_out, s_out, s_row, s_col, s_last,
        input  dp_rdy_in, dp_vld_in, s_in, score_rdy_in
    );

    modport slave (
        input  q_idx, k_idx, dp_vld_out, dp_rdy_out,
        input  score_vld_out, s_out, s_row, s_col, s_last,
        output dp_rdy_in, dp_vld_in, s_in, score_rdy_in
    );
endinterface

// File: rtl/qk_score_scheduler.sv
// qk_score_scheduler
// Walks one Q tile x K tile in row-major order and feeds (q_idx, k_idx) pairs
// to the QK dot-product unit. Each issued pair leaves a {row, col, last} tag in
// a small in-order FIFO. Returning scores are matched to that FIFO head and
// forwarded downstream with their tag.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         launch a tile (IDLE only); n_q/n_k are latched with it
//   n_q, n_k      valid Q / K rows in this tile (0 gives an empty tile)
//   busy          high while issuing or draining
//   done          one-cycle pulse when the tile completes
//   err           sticky: a score arrived with no outstanding tag
//   bus           dot-product and downstream handshakes (master side)
module qk_score_scheduler #(
    parameter int BR        = 8,
    parameter int BC        = 8,
    parameter int TAG_DEPTH = 4,
    parameter int INT_WIDTH = 16,
    parameter int ROW_W     = (BR > 1) ? $clog2(BR) : 1,
    parameter int COL_W     = (BC > 1) ? $clog2(BC) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_W:0]       n_q,
    input  logic [COL_W:0]       n_k,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    qk_score_scheduler_if.master bus
);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int TAG_W = ROW_W + COL_W + 1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t           state;
    logic [ROW_W:0]   nq_r;
    logic [COL_W:0]   nk_r;
    logic [ROW_W-1:0] q_cnt;
    logic [COL_W-1:0] k_cnt;

    logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   tag_cnt;
    logic [TAG_W-1:0] head;

    logic tag_full;
    logic tag_empty;
    logic issue_fire;
    logic pop_fire;
    logic k_last;
    logic last_pair;

    // Full/empty come from the registered count only. A same-cycle pop does
    // not make room for a push.
    assign tag_full  = (tag_cnt == CNT_FULL);
    assign tag_empty = (tag_cnt == '0);

    assign bus.dp_vld_out = (state == ISSUE) && !tag_full;
    assign issue_fire     = bus.dp_vld_out && bus.dp_rdy_in;
    assign bus.q_idx      = q_cnt;
    assign bus.k_idx      = k_cnt;

    assign k_last    = ({1'b0, k_cnt} == nk_r - 1'b1);
    assign last_pair = k_last && ({1'b0, q_cnt} == nq_r - 1'b1);

    // The dot-product passes its ready straight through, so stalling
    // downstream also stalls the dot-product output.
    assign bus.dp_rdy_out    = bus.score_rdy_in;
    assign bus.score_vld_out = bus.dp_vld_in && !tag_empty;
    assign pop_fire          = bus.score_vld_out && bus.score_rdy_in;

    assign head       = tag_mem[rd_ptr];
    assign bus.s_out  = bus.s_in;
    assign bus.s_row  = head[TAG_W-1 -: ROW_W];
    assign bus.s_col  = head[COL_W:1];
    assign bus.s_last = head[0];

    // Tile sequencer. done and busy are registered and set on the state
    // transitions, so they line up exactly with the DONE and ISSUE/DRAIN states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            nq_r  <= '0;
            nk_r  <= '0;
            q_cnt <= '0;
            k_cnt <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        nq_r  <= n_q;
                        nk_r  <= n_k;
                        q_cnt <= '0;
                        k_cnt <= '0;
                        if (n_q == '0 || n_k == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        if (k_last) begin
                            k_cnt <= '0;
                            q_cnt <= q_cnt + 1'b1;
                        end else begin
                            k_cnt <= k_cnt + 1'b1;
                        end
                        if (last_pair) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (tag_empty && !bus.score_vld_out) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // In-flight tag FIFO. The storage is also cleared so the tag outputs read
    // zero after reset. A result with no tag is dropped and latches err.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (issue_fire) begin
                tag_mem[wr_ptr] <= {q_cnt, k_cnt, last_pair};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({issue_fire, pop_fire})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
            if (bus.dp_vld_in && tag_empty) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qk_score_scheduler.sv
// tb_qk_score_scheduler
// Drives qk_score_scheduler through whole tiles. The dot-product is modelled
// as an elastic 1-cycle-latency pipe. Expected tags and scores are queued at
// issue time and compared when the DUT hands a score downstream.
module tb_qk_score_scheduler;
    localparam int BR        = 8;
    localparam int BC        = 8;
    localparam int TAG_DEPTH = 4;
    localparam int INT_WIDTH = 16;
    localparam int ROW_W     = 3;
    localparam int COL_W     = 3;

    typedef struct packed {
        logic [ROW_W-1:0]     row;
        logic [COL_W-1:0]     col;
        logic                 last;
        logic [INT_WIDTH-1:0] score;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [ROW_W:0] n_q;
    logic [COL_W:0] n_k;
    logic           busy;
    logic           done;
    logic           err;

    qk_score_scheduler_if #(.ROW_W(ROW_W), .COL_W(COL_W), .INT_WIDTH(INT_WIDTH)) bus ();

    qk_score_scheduler #(
        .BR(BR), .BC(BC), .TAG_DEPTH(TAG_DEPTH), .INT_WIDTH(INT_WIDTH),
        .ROW_W(ROW_W), .COL_W(COL_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_q(n_q), .n_k(n_k),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t                 sb[$];
    logic [INT_WIDTH-1:0] dp_q[$];

    bit  monitor = 1'b0;
    bit  issuing = 1'b0;
    bit  force_dp_vld = 1'b0;
    int  rdy_mode = 0;
    int  tile_nq, tile_nk, exp_q, exp_k;
    int  issued, scored, max_occ;
    int  cyc = 0, start_cyc, done_cyc, done_count = 0, done_base;
    bit  busy_seen;
    logic [33:0] snap_zero;
    logic [INT_WIDTH+ROW_W+COL_W:0] snap_tag;
    logic snap_dv;

    // One clock cycle: sample and check at the falling edge, then update the
    // dot-product model and drive inputs just after the rising edge.
    task automatic tick();
        bit issue_fire, pop_fire, score_fire, exp_dv, exp_sv, lastp, pushed;
        logic [INT_WIDTH-1:0] sc;
        exp_t e;
        pushed = 1'b0;
        sc = '0;
        @(negedge clk);
        issue_fire = bus.dp_vld_out && bus.dp_rdy_in;
        pop_fire   = bus.dp_vld_in && bus.dp_rdy_out;
        score_fire = bus.score_vld_out && bus.score_rdy_in;
        snap_zero  = {busy, done, err, bus.dp_vld_out, bus.score_vld_out, bus.q_idx,
                      bus.k_idx, bus.s_row, bus.s_col, bus.s_last, bus.s_out};
        snap_tag   = {bus.s_out, bus.s_row, bus.s_col, bus.s_last};
        snap_dv    = bus.dp_vld_out;
        if (done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen = 1'b1;
        if (monitor) begin
            if (sb.size() > max_occ) max_occ = sb.size();
            exp_dv = issuing && (sb.size() < TAG_DEPTH);
            checks++;
            if (bus.dp_vld_out !== exp_dv) begin
                errors++;
                $display("[TB] FAIL dp_vld_out cyc=%0d: got %b, expected %b", cyc, bus.dp_vld_out, exp_dv);
            end
            exp_sv = bus.dp_vld_in && (sb.size() != 0);
            checks++;
            if (bus.score_vld_out !== exp_sv) begin
                errors++;
                $display("[TB] FAIL score_vld_out cyc=%0d: got %b, expected %b", cyc, bus.score_vld_out, exp_sv);
            end
            checks++;
            if (bus.dp_rdy_out !== bus.score_rdy_in) begin
                errors++;
                $display("[TB] FAIL dp_rdy_out cyc=%0d: got %b, expected %b", cyc, bus.dp_rdy_out, bus.score_rdy_in);
            end
            if (score_fire) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_score cyc=%0d: got score with tag (%0d,%0d), expected none",
                             cyc, bus.s_row, bus.s_col);
                end else begin
                    e = sb.pop_front();
                    scored++;
                    if ({bus.s_row, bus.s_col, bus.s_last, bus.s_out} !== e) begin
                        errors++;
                        $display("[TB] FAIL score_tag cyc=%0d: got row=%0d col=%0d last=%b s=%h, expected row=%0d col=%0d last=%b s=%h",
                                 cyc, bus.s_row, bus.s_col, bus.s_last, bus.s_out, e.row, e.col, e.last, e.score);
                    end
                end
            end
            if (issue_fire) begin
                checks++;
                if (!issuing) begin
                    errors++;
                    $display("[TB] FAIL unexpected_issue cyc=%0d: got issue (%0d,%0d), expected none",
                             cyc, bus.q_idx, bus.k_idx);
                end else begin
                    if ({bus.q_idx, bus.k_idx} !== {ROW_W'(exp_q), COL_W'(exp_k)}) begin
                        errors++;
                        $display("[TB] FAIL issue_idx cyc=%0d: got (%0d,%0d), expected (%0d,%0d)",
                                 cyc, bus.q_idx, bus.k_idx, exp_q, exp_k);
                    end
                    lastp = (exp_q == tile_nq - 1) && (exp_k == tile_nk - 1);
                    sc = INT_WIDTH'($urandom);
                    sb.push_back('{row: ROW_W'(exp_q), col: COL_W'(exp_k), last: lastp, score: sc});
                    pushed = 1'b1;
                    issued++;
                    if (exp_k == tile_nk - 1) begin
                        exp_k = 0;
                        exp_q++;
                    end else begin
                        exp_k++;
                    end
                    if (lastp) issuing = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (monitor && pop_fire && dp_q.size() != 0) dp_q.delete(0);
        if (pushed) dp_q.push_back(sc);
        bus.dp_vld_in = force_dp_vld || (dp_q.size() != 0);
        bus.s_in      = (dp_q.size() != 0) ? dp_q[0] : '0;
        case (rdy_mode)
            1:       bus.score_rdy_in = ~bus.score_rdy_in;
            2:       bus.score_rdy_in = 1'b0;
            default: bus.score_rdy_in = 1'b1;
        endcase
    endtask

    task automatic do_reset();
        monitor = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        tick();
        tick();
        sb.delete();
        dp_q.delete();
        issuing = 1'b0;
        bus.dp_vld_in = force_dp_vld;
        bus.s_in = '0;
        rst = 1'b0;
        monitor = 1'b1;
    endtask

    task automatic start_tile(input int nq, input int nk);
        n_q = (ROW_W+1)'(nq);
        n_k = (COL_W+1)'(nk);
        start = 1'b1;
        tile_nq = nq;
        tile_nk = nk;
        exp_q = 0;
        exp_k = 0;
        issued = 0;
        scored = 0;
        max_occ = 0;
        done_base = done_count;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        n_q = 4'd1;
        n_k = 4'd1;
        busy_seen = 1'b0;
        issuing = (nq != 0) && (nk != 0);
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while (done_count == done_base && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_count == done_base) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got no done after %0d cycles, expected done", name, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (snap_zero !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h, expected 0", snap_zero);
        end
    endtask

    task automatic test_basic_tile();
        rdy_mode = 0;
        start_tile(2, 3);
        run_until_done(40, "basic");
        checks++;
        if (done_cyc - start_cyc != 9) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d, expected 9", done_cyc - start_cyc);
        end
        checks++;
        if (scored != 6) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d, expected 6", scored);
        end
        checks++;
        if (busy_seen !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_busy_err: got busy_seen=%b err=%b, expected 1 0", busy_seen, err);
        end
        tick();
        checks++;
        if (done_count - done_base != 1) begin
            errors++;
            $display("[TB] FAIL basic_done_pulses: got %0d, expected 1", done_count - done_base);
        end
    endtask

    task automatic test_toggle_ready();
        rdy_mode = 1;
        start_tile(8, 8);
        run_until_done(400, "toggle");
        rdy_mode = 0;
        checks++;
        if (scored != 64 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL toggle_count: got %0d scores %0d left, expected 64 scores 0 left", scored, sb.size());
        end
        checks++;
        if (max_occ > TAG_DEPTH) begin
            errors++;
            $display("[TB] FAIL toggle_occupancy: got %0d, expected at most %0d", max_occ, TAG_DEPTH);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL toggle_err: got %b, expected 0", err);
        end
    endtask

    task automatic test_stall_full();
        logic [INT_WIDTH+ROW_W+COL_W:0] held;
        rdy_mode = 0;
        start_tile(4, 4);
        tick();
        tick();
        tick();
        rdy_mode = 2;
        bus.score_rdy_in = 1'b0;
        tick();
        held = snap_tag;
        for (int i = 1; i < 10; i++) tick();
        checks++;
        if (snap_dv !== 1'b0 || sb.size() != TAG_DEPTH) begin
            errors++;
            $display("[TB] FAIL stall_full: got dp_vld_out=%b tags=%0d, expected 0 and %0d", snap_dv, sb.size(), TAG_DEPTH);
        end
        checks++;
        if (snap_tag !== held) begin
            errors++;
            $display("[TB] FAIL stall_stable: got %h, expected %h", snap_tag, held);
        end
        rdy_mode = 0;
        bus.score_rdy_in = 1'b1;
        run_until_done(100, "stall");
        checks++;
        if (scored != 16 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d scores %0d left, expected 16 scores 0 left", scored, sb.size());
        end
    endtask

    task automatic test_empty_tile();
        rdy_mode = 0;
        start_tile(3, 0);
        tick();
        tick();
        checks++;
        if (done_count - done_base != 1 || done_cyc - start_cyc != 1) begin
            errors++;
            $display("[TB] FAIL empty_done: got pulses=%0d at +%0d, expected 1 at +1",
                     done_count - done_base, done_cyc - start_cyc);
        end
        checks++;
        if (busy_seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_busy: got %b, expected 0", busy_seen);
        end
    endtask

    task automatic test_reset_mid_tile();
        int n = 0;
        rdy_mode = 0;
        start_tile(4, 4);
        while (issued < 4 && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (issued != 4) begin
            errors++;
            $display("[TB] FAIL midreset_progress: got %0d issues, expected 4", issued);
        end
        do_reset();
        done_base = done_count;
        tick();
        checks++;
        if (snap_zero !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h, expected 0", snap_zero);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (done_count != done_base) begin
            errors++;
            $display("[TB] FAIL midreset_no_done: got %0d pulses, expected 0", done_count - done_base);
        end
        start_tile(4, 4);
        run_until_done(60, "midreset");
        checks++;
        if (scored != 16 || done_cyc - start_cyc != 19) begin
            errors++;
            $display("[TB] FAIL midreset_rerun: got %0d scores latency %0d, expected 16 and 19",
                     scored, done_cyc - start_cyc);
        end
    endtask

    task automatic test_err_idle();
        force_dp_vld = 1'b1;
        bus.dp_vld_in = 1'b1;
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || snap_zero[29] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_set: got err=%b score_vld_out=%b, expected 1 0", err, snap_zero[29]);
        end
        force_dp_vld = 1'b0;
        bus.dp_vld_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: got %b, expected 1", err);
        end
        do_reset();
        tick();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_cleared: got %b, expected 0", err);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        n_q = '0;
        n_k = '0;
        bus.dp_rdy_in = 1'b1;
        bus.dp_vld_in = 1'b0;
        bus.s_in = '0;
        bus.score_rdy_in = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_tile();
        test_toggle_ready();
        test_stall_full();
        test_empty_tile();
        test_reset_mid_tile();
        test_err_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
